// File: rtl/booth_mult_if.sv
// booth_mult_if: operand/result handshake bundle for the sequential Booth multiplier
interface booth_mult_if #(parameter int WIDTH = 8);
  logic start;
  logic in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic out_valid;
  logic out_ready;
  logic [2*WIDTH-1:0] product;
  logic busy;
  modport master(output start, a, b, out_ready, input in_ready, out_valid, product, busy);
  modport slave(input start, a, b, out_ready, output in_ready, out_valid, product, busy);
endinterface

// File: rtl/booth_mult_seq.sv
// booth_mult_seq: radix-4 Booth multiplier sequencer driving an external booth_encoder; BOOTH_EARLY_TERM_EN enables early termination
module booth_mult_seq #(parameter int WIDTH = 8) (
  input logic clk,
  input logic rst,
  booth_mult_if.slave bus,
  output logic [WIDTH-1:0] enc_x,
  output logic [2:0] enc_operand,
  input logic [2*WIDTH-1:0] enc_pp
);
  localparam int STEPS = WIDTH / 2;
  localparam int CW = (STEPS > 1) ? $clog2(STEPS) : 1;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] xa;
  logic [WIDTH-1:0] mb;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0] cnt;
  logic last;
  assign bus.in_ready = state == IDLE;
  assign bus.out_valid = state == DONE;
  assign bus.busy = state != IDLE;
  assign bus.product = acc;
  assign enc_x = xa;
  // triplet k is bits {2k+1, 2k, 2k-1} of the multiplier with an implicit zero below bit 0
  assign enc_operand = state == CALC ? 3'({mb, 1'b0} >> {cnt, 1'b0}) : 3'b000;
`ifdef BOOTH_EARLY_TERM_EN
  logic signed [WIDTH-1:0] rem;
  // remaining multiplier bits all equal means every later Booth digit is zero
  assign rem = $signed(mb) >>> {cnt, 1'b1};
  assign last = rem == '0 || rem == '1;
`else
  assign last = cnt == CW'(STEPS - 1);
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc <= '0;
      cnt <= '0;
      xa <= '0;
      mb <= '0;
    end else if (state == IDLE) begin
      if (bus.start) begin
        state <= CALC;
        xa <= bus.a;
        mb <= bus.b;
        acc <= '0;
        cnt <= '0;
      end
    end else if (state == CALC) begin
      acc <= acc + (enc_pp << {cnt, 1'b0});
      cnt <= last ? cnt : cnt + 1'b1;
      state <= last ? DONE : CALC;
    end else if (bus.out_ready) begin
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_booth_mult_seq.sv
// tb_booth_mult_seq: randomized and directed checks of booth_mult_seq against an arithmetic reference
module tb_booth_mult_seq;
  localparam int W = 8;
`ifdef BOOTH_EARLY_TERM_EN
  localparam bit ET = 1'b1;
`else
  localparam bit ET = 1'b0;
`endif
  logic clk;
  logic rst;
  logic [W-1:0] enc_x;
  logic [2:0] enc_operand;
  logic [2*W-1:0] enc_pp;
  int checks = 0;
  int errors = 0;
  logic [2:0] ops[$];
  booth_mult_if #(.WIDTH(W)) bus();
  booth_mult_seq #(.WIDTH(W)) dut(
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .enc_x(enc_x),
    .enc_operand(enc_operand),
    .enc_pp(enc_pp)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic int digit(logic [2:0] t);
    return -2 * int'(t[2]) + int'(t[1]) + int'(t[0]);
  endfunction
  assign enc_pp = (2*W)'(int'($signed(enc_x)) * digit(enc_operand));
  function automatic logic [2*W-1:0] prod(logic [W-1:0] x, logic [W-1:0] y);
    logic signed [2*W-1:0] sx;
    logic signed [2*W-1:0] sy;
    sx = $signed(x);
    sy = $signed(y);
    return sx * sy;
  endfunction
  function automatic int steps(logic [W-1:0] m);
    logic [W:0] mx;
    int l;
    mx = {m, 1'b0};
    l = 0;
    for (int k = 0; k < W / 2; k++)
      if (digit(3'(mx >> (2 * k))) != 0) l = k;
    return ET ? l + 1 : W / 2;
  endfunction
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask
  // phase-level reference: 0 idle, 1 multiplying, 2 result held
  int ph = 0;
  int k = 0;
  int left = 0;
  bit live = 0;
  logic [W-1:0] ma = '0;
  logic [W-1:0] mbv = '0;
  logic [2*W-1:0] exp_p = '0;
  always @(posedge clk) begin
    live = 1;
    if (rst) begin
      ph = 0; k = 0; ma = '0; mbv = '0; exp_p = '0;
    end else if (ph == 0) begin
      if (bus.start) begin
        ph = 1; k = 0; ma = bus.a; mbv = bus.b; left = steps(bus.b); exp_p = '0;
      end
    end else if (ph == 1) begin
      k++;
      if (k == left) begin
        ph = 2;
        exp_p = prod(ma, mbv);
      end
    end else if (bus.out_ready) begin
      ph = 0;
    end
  end
  always @(negedge clk) begin
    if (live) begin
      chk("in_ready", 32'(bus.in_ready), 32'(ph == 0));
      chk("busy", 32'(bus.busy), 32'(ph != 0));
      chk("out_valid", 32'(bus.out_valid), 32'(ph == 2));
      if (ph == 1) begin
        chk("enc_x", 32'(enc_x), 32'(ma));
        chk("enc_operand", 32'(enc_operand), 32'(3'({mbv, 1'b0} >> (2 * k))));
      end else begin
        chk("enc_operand_idle", 32'(enc_operand), 32'd0);
        chk("product", 32'(bus.product), 32'(exp_p));
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_ready(input string n);
    int t = 0;
    while (!bus.in_ready && t < 50) begin
      tick();
      t++;
    end
    chk({n, "_ready"}, 32'(bus.in_ready), 32'd1);
  endtask
  task automatic mult(input logic [W-1:0] x, input logic [W-1:0] y, input logic [2*W-1:0] ep, input int el, input string n);
    int lat = 0;
    ops.delete();
    wait_ready(n);
    bus.a = x;
    bus.b = y;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    while (!bus.out_valid && lat < 50) begin
      ops.push_back(enc_operand);
      tick();
      lat++;
    end
    chk({n, "_latency"}, 32'(lat), 32'(el));
    chk({n, "_product"}, 32'(bus.product), 32'(ep));
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [2:0] e1[$];
    int t;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.out_ready = 1'b1;
    repeat (2) tick();
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_product", 32'(bus.product), 32'd0);
    chk("rst_enc_x", 32'(enc_x), 32'd0);
    chk("rst_enc_operand", 32'(enc_operand), 32'd0);
    rst = 1'b0;
    mult(8'hA7, 8'h03, 16'hFEF5, ET ? 2 : 4, "t1");
    e1 = {3'b110, 3'b001};
    if (!ET) e1 = {e1, 3'b000, 3'b000};
    chk("t1_seq_len", 32'(ops.size()), 32'(e1.size()));
    for (int i = 0; i < e1.size() && i < ops.size(); i++)
      chk("t1_seq", 32'(ops[i]), 32'(e1[i]));
    mult(8'h80, 8'h80, 16'h4000, 4, "t2a");
    mult(8'h7F, 8'h7F, 16'h3F01, 4, "t2b");
    mult(8'h7F, 8'h80, 16'hC080, 4, "t2c");
    wait_ready("t3");
    bus.out_ready = 1'b0;
    bus.a = 8'h7F;
    bus.b = 8'h7F;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    t = 0;
    while (!bus.out_valid && t < 50) begin
      tick();
      t++;
    end
    for (int i = 0; i < 5; i++) begin
      bus.start = 1'b1;
      tick();
      chk("t3_hold_valid", 32'(bus.out_valid), 32'd1);
      chk("t3_hold_in_ready", 32'(bus.in_ready), 32'd0);
      chk("t3_hold_product", 32'(bus.product), 32'h3F01);
    end
    bus.start = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    chk("t3_release_valid", 32'(bus.out_valid), 32'd0);
    chk("t3_release_in_ready", 32'(bus.in_ready), 32'd1);
    wait_ready("t4");
    bus.a = 8'h7F;
    bus.b = 8'h55;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t4_in_ready", 32'(bus.in_ready), 32'd1);
    chk("t4_busy", 32'(bus.busy), 32'd0);
    chk("t4_product", 32'(bus.product), 32'd0);
    mult(8'h05, 8'hFD, 16'hFFF1, ET ? 2 : 4, "t4m");
    wait_ready("t5");
    bus.a = 8'h02;
    bus.b = 8'h03;
    bus.start = 1'b1;
    t = 0;
    while (!bus.out_valid && t < 50) begin
      tick();
      t++;
    end
    chk("t5a_product", 32'(bus.product), 32'h0006);
    chk("t5a_in_ready", 32'(bus.in_ready), 32'd0);
    bus.a = 8'hFC;
    bus.b = 8'h06;
    tick();
    t = 0;
    while (!bus.out_valid && t < 50) begin
      tick();
      t++;
    end
    chk("t5b_latency", 32'(t), 32'(ET ? 3 : 5));
    chk("t5b_product", 32'(bus.product), 32'hFFE8);
    bus.start = 1'b0;
    mult(8'h5A, 8'h00, 16'h0000, ET ? 1 : 4, "t6a");
    mult(8'h10, 8'hFF, 16'hFFF0, ET ? 1 : 4, "t6b");
    repeat (600) begin
      tick();
      bus.start = 1'($urandom);
      bus.a = ($urandom % 8 == 0) ? 8'h80 : W'($urandom);
      bus.b = ($urandom % 8 == 0) ? 8'h80 : (($urandom % 8 == 0) ? W'($urandom % 4) : W'($urandom));
      bus.out_ready = ($urandom % 4) != 0;
    end
    bus.start = 1'b0;
    bus.out_ready = 1'b1;
    repeat (20) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/booth_mult_seq.md
Name: booth_mult_seq

Overview:
Sequential radix-4 Booth multiplier controller for the calculator's multiply path. It drives one external booth_encoder instance, one triplet per cycle, and accumulates the shifted signed partial products into a 2*WIDTH product. A start/ready handshake accepts operands and a valid/ready handshake returns the result to the ALU result mux.

Parameters:
WIDTH, 8, operand width in bits; must be even and equal to the attached booth_encoder x width.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
start  input  1  operand request; accepted when start && in_ready at a rising edge
in_ready  output  1  high only in IDLE
a  input  WIDTH  signed multiplicand; sampled on acceptance
b  input  WIDTH  signed multiplier; sampled on acceptance
enc_x  output  WIDTH  to encoder x; latched multiplicand
enc_operand  output  3  to encoder operand; current Booth triplet
enc_pp  input  2*WIDTH  from encoder partial_p; sign-extended x*digit (digit in {0,+1,+2,-1,-2})
out_valid  output  1  product valid; high only in DONE
out_ready  input  1  consumer accepts product when out_valid && out_ready
product  output  2*WIDTH  signed result; held stable while out_valid
busy  output  1  high in CALC or DONE

Behaviour:
- Reset (rst=1 at an edge, any state, including mid-operation): state=IDLE, acc=0, cnt=0, latched a/b=0. Resulting outputs: in_ready=1, out_valid=0, busy=0, product=0, enc_x=0, enc_operand=000.
- States: IDLE, CALC, DONE.
- IDLE: in_ready=1. On start: latch a->xa, b->mb, acc<=0, cnt<=0, go to CALC. start with in_ready=0 is ignored, not queued.
- CALC: enc_x=xa. enc_operand={mb[2*cnt+1], mb[2*cnt], (cnt==0 ? 0 : mb[2*cnt-1])}. Combinational enc_pp is consumed in the same cycle. Each edge: acc <= acc + (enc_pp << 2*cnt), truncated modulo 2^(2*WIDTH); cnt<=cnt+1. When cnt==WIDTH/2-1, go to DONE.
- DONE: out_valid=1, product=acc. On out_ready: go to IDLE. start is not accepted in the same cycle because in_ready=0.
- product equals acc in all states and is zeroed at the next acceptance. enc_operand=000 outside CALC.
- Latency (without the optional feature): accept at edge N; out_valid=1 after edge N+WIDTH/2. Throughput is one multiply per WIDTH/2+2 cycles minimum.
- cnt width is clog2(WIDTH/2), with a minimum of 1; it never wraps inside CALC.
- Arithmetic is two's complement. -2^(W-1) * -2^(W-1) = 2^(2W-2), which fits in 2*WIDTH bits with no overflow.

Optional Feature:
BOOTH_EARLY_TERM_EN
- Defined: in CALC, after accumulating step cnt, if mb[WIDTH-1:2*cnt+1] is all 0s or all 1s, go to DONE immediately. All remaining triplets are 000 or 111, so their digits are zero. Latency becomes (index of the last non-trivial step)+1 cycles, minimum 1.
- Undefined: CALC always runs exactly WIDTH/2 cycles.
- The product value is identical in both builds.

Test Plan:
1. a=0xA7 (-89), b=0x03, WIDTH=8, real booth_encoder attached -> enc_operand sequence 110,001,000,000; product=0xFEF5 (-267); out_valid after 4 edges; with BOOTH_EARLY_TERM_EN, sequence 110,001 only and out_valid after 2 edges.
2. a=0x80, b=0x80 -> product=0x4000. a=0x7F, b=0x7F -> product=0x3F01. a=0x7F, b=0x80 -> product=0xC080.
3. Back-pressure: hold out_ready=0 for 5 cycles after out_valid -> product is stable and out_valid stays 1; start pulses in DONE are ignored (in_ready=0); out_ready=1 -> IDLE next edge.
4. Reset mid-op: assert rst in the 2nd CALC cycle -> next edge in_ready=1, busy=0, product=0. A new multiply of 5*-3 then gives 0xFFF1.
5. Back-to-back: out_ready tied 1, start held 1, operands 2*3 then -4*6 -> products 0x0006 and 0xFFE8, each accepted only in IDLE.
6. b=0x00 -> product=0, with 1 CALC cycle if BOOTH_EARLY_TERM_EN is defined, else 4. b=0xFF, a=0x10 -> product=0xFFF0.
